// File: rtl/light_hold_controller.sv
// Lamp hold/dim controller: turns the movement-detection request into a held,
// PWM-faded lamp drive with wall-switch overrides.
module light_hold_controller #(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned DIM_CYCLES  = 250,
    parameter int unsigned PWM_BITS    = 4,
    parameter int unsigned DIM_DUTY    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_light,
    input  logic       manual_on,
    input  logic       manual_off,
    output logic       lamp,
    output logic [1:0] state,
    output logic       hold_active
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StOn     = 2'd1,
        StDim    = 2'd2,
        StManual = 2'd3
    } state_e;

    localparam int unsigned MaxCycles = (HOLD_CYCLES > DIM_CYCLES) ? HOLD_CYCLES : DIM_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
    localparam int unsigned HoldInt   = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int unsigned DimInt    = (DIM_CYCLES > 0) ? DIM_CYCLES - 1 : 0;
    localparam int unsigned PwmPeriod = 1 << PWM_BITS;
    // Duties at or beyond the PWM period saturate to "always high".
    localparam int unsigned DutyInt   = (DIM_DUTY > PwmPeriod) ? PwmPeriod : DIM_DUTY;

    localparam logic [TimerW-1:0]  HoldLoad = TimerW'(HoldInt);
    localparam logic [TimerW-1:0]  DimLoad  = TimerW'(DimInt);
    localparam logic [PWM_BITS:0]  Duty     = (PWM_BITS + 1)'(DutyInt);

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [PWM_BITS-1:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pwm_q   <= pwm_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (manual_off) begin
            state_d = StIdle;
            timer_d = '0;
        end else if (manual_on) begin
            state_d = StManual;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (auto_light) begin
                        state_d = StOn;
                        timer_d = HoldLoad;
                    end
                end
                StOn: begin
                    if (auto_light) begin
                        timer_d = HoldLoad;
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else if (DIM_CYCLES > 0) begin
                        state_d = StDim;
                        timer_d = DimLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StDim: begin
                    if (auto_light) begin
                        state_d = StOn;
                        timer_d = HoldLoad;
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StManual: begin
                    // Only manual_off (handled above) leaves MANUAL.
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        lamp = 1'b0;
        unique case (state_q)
            StIdle:   lamp = 1'b0;
            StOn:     lamp = 1'b1;
            StDim:    lamp = ({1'b0, pwm_q} < Duty);
            StManual: lamp = 1'b1;
            default:  lamp = 1'b0;
        endcase
    end

    assign state       = state_q;
    assign hold_active = (state_q == StOn) || (state_q == StDim);

endmodule

// File: tb/tb_light_hold_controller.sv
// Directed bench for light_hold_controller: table-driven hold/dim/retrigger
// vectors plus hand-written override and reset sequences.
module tb_light_hold_controller;

    localparam logic [1:0] SIdle   = 2'd0;
    localparam logic [1:0] SOn     = 2'd1;
    localparam logic [1:0] SDim    = 2'd2;
    localparam logic [1:0] SManual = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       auto_light = 1'b0;
    logic       manual_on = 1'b0;
    logic       manual_off = 1'b0;

    logic       lamp, hold_active;
    logic [1:0] state;
    logic       nd_lamp, nd_hold;
    logic [1:0] nd_state;
    logic       full_lamp, full_hold;
    logic [1:0] full_state;
    logic       dark_lamp, dark_hold;
    logic [1:0] dark_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    light_hold_controller #(
        .HOLD_CYCLES(8), .DIM_CYCLES(4), .PWM_BITS(2), .DIM_DUTY(1)
    ) dut (
        .clk(clk), .rst(rst), .auto_light(auto_light), .manual_on(manual_on),
        .manual_off(manual_off), .lamp(lamp), .state(state), .hold_active(hold_active)
    );

    light_hold_controller #(
        .HOLD_CYCLES(8), .DIM_CYCLES(0), .PWM_BITS(2), .DIM_DUTY(1)
    ) dut_nodim (
        .clk(clk), .rst(rst), .auto_light(auto_light), .manual_on(manual_on),
        .manual_off(manual_off), .lamp(nd_lamp), .state(nd_state), .hold_active(nd_hold)
    );

    light_hold_controller #(
        .HOLD_CYCLES(8), .DIM_CYCLES(4), .PWM_BITS(2), .DIM_DUTY(5)
    ) dut_full (
        .clk(clk), .rst(rst), .auto_light(auto_light), .manual_on(manual_on),
        .manual_off(manual_off), .lamp(full_lamp), .state(full_state),
        .hold_active(full_hold)
    );

    light_hold_controller #(
        .HOLD_CYCLES(8), .DIM_CYCLES(4), .PWM_BITS(2), .DIM_DUTY(0)
    ) dut_dark (
        .clk(clk), .rst(rst), .auto_light(auto_light), .manual_on(manual_on),
        .manual_off(manual_off), .lamp(dark_lamp), .state(dark_state),
        .hold_active(dark_hold)
    );

    typedef struct {
        logic       r, a, mon, moff;
        logic [1:0] st;
        logic       lp;
        logic       cv;
        logic [1:0] vst;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic r, input logic a, input logic [1:0] st, input logic lp,
                       input logic cv, input logic [1:0] vst);
        vec_t v;
        v.r = r; v.a = a; v.mon = 1'b0; v.moff = 1'b0;
        v.st = st; v.lp = lp; v.cv = cv; v.vst = vst;
        vecs.push_back(v);
    endtask

    task automatic rows(input int n, input logic [1:0] st, input logic lp, input logic cv,
                        input logic [1:0] vst);
        for (int i = 0; i < n; i++) row(1'b0, 1'b0, st, lp, cv, vst);
    endtask

    task automatic cmp(input string what, input int e, input logic [1:0] act,
                       input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0d, expected %0d", what, e, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic mon, input logic moff);
        rst = r; auto_light = a; manual_on = mon; manual_off = moff;
        @(posedge clk);
        #1;
    endtask

    // Duty variants differ from the main DUT only in DIM lamp level.
    task automatic check(input string tag, input int e, input logic [1:0] st, input logic lp);
        logic hold;
        hold = (st == SOn) || (st == SDim);
        cmp({tag, ".state"}, e, state, st);
        cmp({tag, ".lamp"}, e, {1'b0, lamp}, {1'b0, lp});
        cmp({tag, ".hold"}, e, {1'b0, hold_active}, {1'b0, hold});
        cmp({tag, ".full_lamp"}, e, {1'b0, full_lamp}, {1'b0, (st == SDim) ? 1'b1 : lp});
        cmp({tag, ".dark_lamp"}, e, {1'b0, dark_lamp}, {1'b0, (st == SDim) ? 1'b0 : lp});
    endtask

    initial begin
        int e;

        // Single trigger at edge 10; nodim variant checked alongside.
        row(1'b1, 1'b0, SIdle, 1'b0, 1'b1, SIdle);
        rows(9, SIdle, 1'b0, 1'b1, SIdle);
        row(1'b0, 1'b1, SOn, 1'b1, 1'b1, SOn);
        rows(7, SOn, 1'b1, 1'b1, SOn);
        row(1'b0, 1'b0, SDim, 1'b0, 1'b1, SIdle);   // 18, pwm 2
        row(1'b0, 1'b0, SDim, 1'b0, 1'b1, SIdle);   // 19, pwm 3
        row(1'b0, 1'b0, SDim, 1'b1, 1'b1, SIdle);   // 20, pwm 0
        row(1'b0, 1'b0, SDim, 1'b0, 1'b1, SIdle);   // 21, pwm 1
        rows(2, SIdle, 1'b0, 1'b1, SIdle);

        // Retrigger during ON at edge 15.
        row(1'b1, 1'b0, SIdle, 1'b0, 1'b0, SIdle);
        rows(9, SIdle, 1'b0, 1'b0, SIdle);
        row(1'b0, 1'b1, SOn, 1'b1, 1'b0, SIdle);
        rows(4, SOn, 1'b1, 1'b0, SIdle);
        row(1'b0, 1'b1, SOn, 1'b1, 1'b0, SIdle);
        rows(7, SOn, 1'b1, 1'b0, SIdle);
        row(1'b0, 1'b0, SDim, 1'b0, 1'b0, SIdle);   // 23
        row(1'b0, 1'b0, SDim, 1'b1, 1'b0, SIdle);   // 24
        rows(2, SDim, 1'b0, 1'b0, SIdle);           // 25, 26
        rows(2, SIdle, 1'b0, 1'b0, SIdle);

        // Retrigger from DIM at edge 19.
        row(1'b1, 1'b0, SIdle, 1'b0, 1'b0, SIdle);
        rows(9, SIdle, 1'b0, 1'b0, SIdle);
        row(1'b0, 1'b1, SOn, 1'b1, 1'b0, SIdle);
        rows(7, SOn, 1'b1, 1'b0, SIdle);
        row(1'b0, 1'b0, SDim, 1'b0, 1'b0, SIdle);   // 18
        row(1'b0, 1'b1, SOn, 1'b1, 1'b0, SIdle);    // 19
        rows(7, SOn, 1'b1, 1'b0, SIdle);
        row(1'b0, 1'b0, SDim, 1'b0, 1'b0, SIdle);   // 27
        row(1'b0, 1'b0, SDim, 1'b1, 1'b0, SIdle);   // 28
        rows(2, SDim, 1'b0, 1'b0, SIdle);
        row(1'b0, 1'b0, SIdle, 1'b0, 1'b0, SIdle);  // 31

        e = 0;
        foreach (vecs[i]) begin
            if (vecs[i].r) e = 0;
            step(vecs[i].r, vecs[i].a, vecs[i].mon, vecs[i].moff);
            check("table", e, vecs[i].st, vecs[i].lp);
            if (vecs[i].cv) cmp("nodim.state", e, nd_state, vecs[i].vst);
            e++;
        end

        // Manual override sequence.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("manual", 0, SIdle, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("manual", k, SIdle, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("manual", 5, SManual, 1'b1);
        for (int k = 6; k <= 59; k++) begin
            step(1'b0, k[0], 1'b0, 1'b0);
            check("manual", k, SManual, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);  check("manual", 60, SIdle, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("manual", 61, SIdle, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);  check("manual", 62, SManual, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);  check("both", 63, SIdle, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);  check("manual", 64, SOn, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);  check("on_over_auto", 65, SManual, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);  check("auto_ignored", 66, SManual, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);  check("off_over_auto", 67, SIdle, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("manual", 68, SIdle, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);  check("manual", 69, SOn, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);  check("off_in_on", 70, SIdle, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("off_in_on", 71, SIdle, 1'b0);

        // Reset mid-hold (pwm restarts at edge 14), then reset in MANUAL.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset", 0, SIdle, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("reset", k, SIdle, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset", 10, SOn, 1'b1);
        for (int k = 11; k <= 13; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("reset", k, SOn, 1'b1);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);  check("reset_in_on", 14, SIdle, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("reset", 15, SIdle, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);  check("reset", 16, SOn, 1'b1);
        for (int k = 17; k <= 23; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("reset", k, SOn, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("reset", 24, SDim, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("reset", 25, SDim, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("reset", 26, SDim, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("reset", 27, SDim, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("reset", 28, SIdle, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);  check("reset", 29, SManual, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);  check("reset_in_manual", 30, SIdle, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);  check("reset_in_manual", 31, SIdle, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
